// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Reads back a multiplexed 7-segment display bus and recovers the BCD digit
// shown at each position.
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   seg_in       segment lines, active-high, [6]=a .. [0]=g
//   dig_sel      one-hot active-high digit enable, bit i = digit i
//   bcd_out      recovered digits, nibble i = digit i (4'hF for illegal glyph)
//   digit_err    digit i last captured an illegal glyph
//   frame_valid  one-cycle pulse once every digit has been captured
//   frame_err    OR of digit_err, qualified by frame_valid
//   stale        no capture for TIMEOUT_CYCLES cycles
module seg7_scan_decoder #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {
    TRACK,
    HOLD
  } state_e;

  state_e                  state_q;
  logic [6:0]              seg_s1_q, seg_s2_q, seg_prev_q;
  logic [NUM_DIGITS-1:0]   sel_s1_q, sel_s2_q, sel_prev_q;
  logic [CW-1:0]           cnt_q;
  logic [TW-1:0]           tcnt_q;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    fv_q, ferr_q;

  logic       same;
  logic       onehot;
  logic       stable_hit;
  logic       capture;
  logic       frame_done;
  logic [3:0] glyph_code;
  logic       glyph_bad;

  always_comb begin
    glyph_bad  = 1'b0;
    glyph_code = 4'hF;
    case (seg_s2_q)
      7'b1111110: glyph_code = 4'd0;
      7'b0110000: glyph_code = 4'd1;
      7'b1101101: glyph_code = 4'd2;
      7'b1111001: glyph_code = 4'd3;
      7'b0110011: glyph_code = 4'd4;
      7'b1011011: glyph_code = 4'd5;
      7'b1011111: glyph_code = 4'd6;
      7'b1110000: glyph_code = 4'd7;
      7'b1111111: glyph_code = 4'd8;
      7'b1111011: glyph_code = 4'd9;
      default: begin
        glyph_code = 4'hF;
        glyph_bad  = 1'b1;
      end
    endcase
  end

  always_comb begin
    same   = (seg_s2_q == seg_prev_q) && (sel_s2_q == sel_prev_q);
    onehot = (sel_s2_q != '0) && ((sel_s2_q & (sel_s2_q - 1'b1)) == '0);
    // cnt counts equal comparisons after the first differing one; reaching
    // STABLE_CYCLES-2 here lands the capture on edge 2+STABLE_CYCLES.
    stable_hit = (state_q == TRACK) && same && (cnt_q == CW'(STABLE_CYCLES - 2));
    capture    = stable_hit && onehot;
  end

  always_comb begin
    bcd_d  = bcd_q;
    err_d  = err_q;
    mask_d = mask_q;
    if (capture) begin
      mask_d = mask_q | sel_s2_q;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (sel_s2_q[i]) begin
          bcd_d[4*i +: 4] = glyph_code;
          err_d[i]        = glyph_bad;
        end
      end
    end
    frame_done = capture && (&mask_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      seg_prev_q <= '0;
      sel_s1_q   <= '0;
      sel_s2_q   <= '0;
      sel_prev_q <= '0;
      state_q    <= TRACK;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      mask_q     <= '0;
      bcd_q      <= '0;
      err_q      <= '0;
      fv_q       <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      seg_s1_q   <= seg_in;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      sel_s1_q   <= dig_sel;
      sel_s2_q   <= sel_s1_q;
      sel_prev_q <= sel_s2_q;

      case (state_q)
        TRACK: begin
          if (!same) begin
            cnt_q <= '0;
          end else if (stable_hit) begin
            // A stable non-one-hot sample also parks here so it never
            // captures later without first changing.
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HOLD: begin
          if (!same) begin
            state_q <= TRACK;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= TRACK;
          cnt_q   <= '0;
        end
      endcase

      bcd_q <= bcd_d;
      err_q <= err_d;

      if (frame_done) begin
        mask_q <= '0;
        fv_q   <= 1'b1;
        ferr_q <= |err_d;
      end else begin
        mask_q <= mask_d;
        fv_q   <= 1'b0;
        ferr_q <= 1'b0;
      end

      if (capture) begin
        tcnt_q <= '0;
      end else if (tcnt_q != TW'(TIMEOUT_CYCLES)) begin
        tcnt_q <= tcnt_q + TW'(1);
      end
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_err   = err_q;
  assign frame_valid = fv_q;
  assign frame_err   = ferr_q;
  assign stale       = (tcnt_q == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
// Directed bench for seg7_scan_decoder at default parameters
// (4 digits, 4-sample stability, 1024-cycle timeout).
module tb_seg7_scan_decoder;

  localparam logic [6:0] G0   = 7'b1111110;
  localparam logic [6:0] G1   = 7'b0110000;
  localparam logic [6:0] G2   = 7'b1101101;
  localparam logic [6:0] G3   = 7'b1111001;
  localparam logic [6:0] G4   = 7'b0110011;
  localparam logic [6:0] G5   = 7'b1011011;
  localparam logic [6:0] G6   = 7'b1011111;
  localparam logic [6:0] G7   = 7'b1110000;
  localparam logic [6:0] G8   = 7'b1111111;
  localparam logic [6:0] G9   = 7'b1111011;
  localparam logic [6:0] GBAD = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_sel = '0;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        frame_err;
  logic        stale;

  int n_checks = 0;
  int n_errors = 0;
  int fv_count = 0;

  seg7_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .dig_sel    (dig_sel),
    .bcd_out    (bcd_out),
    .digit_err  (digit_err),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_valid === 1'b1) fv_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] sel, input logic [6:0] seg);
    dig_sel = sel;
    seg_in  = seg;
  endtask

  // Present a glyph and stop just after its capture edge.
  task automatic show(input logic [3:0] sel, input logic [6:0] seg);
    drive(sel, seg);
    cycles(6);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset asserted from a non-zero-time edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_err", 32'(digit_err), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);
    #19 rst_n = 1'b1;
    cycles(1);

    // Single capture: digit 0 shows 3, capture on 6th edge after change.
    drive(4'b0001, G3);
    cycles(5);
    check("single_pre", 32'(bcd_out), 32'h0);
    cycles(1);
    check("single_bcd", 32'(bcd_out), 32'h0003);
    check("single_err", 32'(digit_err), 32'h0);
    check("single_fv", 32'(frame_valid), 32'h0);
    cycles(4);
    check("single_hold", 32'(bcd_out), 32'h0003);
    check("single_fvcnt", 32'(fv_count), 32'd0);

    // Full frame 1,2,3,4 (digit 0 recaptured, no double count).
    show(4'b0001, G1);
    check("ff_d0", 32'(bcd_out), 32'h0001);
    check("ff_d0_fv", 32'(frame_valid), 32'h0);
    cycles(2);
    show(4'b0010, G2);
    check("ff_d1_fv", 32'(frame_valid), 32'h0);
    cycles(2);
    show(4'b0100, G3);
    check("ff_d2_fv", 32'(frame_valid), 32'h0);
    cycles(2);
    show(4'b1000, G4);
    check("ff_bcd", 32'(bcd_out), 32'h4321);
    check("ff_fv", 32'(frame_valid), 32'h1);
    check("ff_ferr", 32'(frame_err), 32'h0);
    cycles(1);
    check("ff_fv_pulse", 32'(frame_valid), 32'h0);
    cycles(1);
    show(4'b0001, G1); cycles(2);
    show(4'b0010, G2); cycles(2);
    show(4'b0100, G3);
    check("ff2_d2_fv", 32'(frame_valid), 32'h0);
    cycles(2);
    show(4'b1000, G4);
    check("ff2_fv", 32'(frame_valid), 32'h1);
    cycles(2);
    check("ff2_fvcnt", 32'(fv_count), 32'd2);

    // Glitch: 3-cycle glyph then blanking; then long multi-hot.
    drive(4'b0010, G9);
    cycles(3);
    drive(4'b0000, G9);
    cycles(10);
    check("glitch_bcd", 32'(bcd_out), 32'h4321);
    drive(4'b0011, G9);
    cycles(20);
    check("multihot_bcd", 32'(bcd_out), 32'h4321);
    check("multihot_fvcnt", 32'(fv_count), 32'd2);

    // Illegal glyph on digit 2, then clean frame with 7.
    show(4'b0001, G1); cycles(2);
    show(4'b0010, G2); cycles(2);
    show(4'b0100, GBAD);
    check("ill_bcd", 32'(bcd_out), 32'h4F21);
    check("ill_err", 32'(digit_err), 32'h4);
    cycles(2);
    show(4'b1000, G4);
    check("ill_fv", 32'(frame_valid), 32'h1);
    check("ill_ferr", 32'(frame_err), 32'h1);
    cycles(2);
    show(4'b0001, G1); cycles(2);
    show(4'b0010, G2); cycles(2);
    show(4'b0100, G7);
    check("fix_err", 32'(digit_err), 32'h0);
    cycles(2);
    show(4'b1000, G4);
    check("fix_bcd", 32'(bcd_out), 32'h4721);
    check("fix_fv", 32'(frame_valid), 32'h1);
    check("fix_ferr", 32'(frame_err), 32'h0);
    cycles(2);

    // Mid-frame reset discards the partial frame.
    show(4'b0001, G5); cycles(2);
    show(4'b0010, G6);
    check("pre_rst_bcd", 32'(bcd_out), 32'h4765);
    cycles(1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_bcd", 32'(bcd_out), 32'h0);
    check("mid_rst_err", 32'(digit_err), 32'h0);
    check("mid_rst_fv", 32'(frame_valid), 32'h0);
    #1 rst_n = 1'b1;
    cycles(5);
    check("post_rst_pre", 32'(bcd_out), 32'h0);
    cycles(1);
    check("post_rst_bcd", 32'(bcd_out), 32'h0060);
    check("post_rst_fvcnt", 32'(fv_count), 32'd4);
    cycles(2);
    show(4'b0100, G2); cycles(2);
    show(4'b1000, G3);
    check("partial_fv", 32'(frame_valid), 32'h0);
    cycles(2);
    show(4'b0001, G5);
    check("rst_frame_bcd", 32'(bcd_out), 32'h3265);
    check("rst_frame_fv", 32'(frame_valid), 32'h1);

    // Timeout: stale exactly 1024 edges after the last capture.
    cycles(1023);
    check("stale_pre", 32'(stale), 32'h0);
    cycles(1);
    check("stale_set", 32'(stale), 32'h1);
    drive(4'b0010, G8);
    cycles(5);
    check("stale_hold", 32'(stale), 32'h1);
    cycles(1);
    check("stale_clr", 32'(stale), 32'h0);
    check("stale_bcd", 32'(bcd_out), 32'h3285);
    check("final_fvcnt", 32'(fv_count), 32'd5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
